atm_account_arbiter: RTL and testbench
======================================

# atm_account_arbiter

Shares one account ledger (the balance register) between NUM_TERM ATM terminal front-ends. Grants exclusive sessions round-robin, executes each owner's withdraw/deposit/query against the ledger with overflow and underflow checks, and revokes idle sessions after a timeout. Sits between the per-terminal ATM controllers and the shared account datapath.

## Interface
- NUM_TERM, 4, number of requesting terminals (2..8)
- AMT_W, 8, amount and balance width
- TIMEOUT, 16, idle cycles before a session is revoked (>=2)
- INIT_BALANCE, 128, ledger value after reset
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state while low
- req  in  NUM_TERM  per-terminal session request, level; held high for the whole session
- op_valid  in  NUM_TERM  per-terminal operation strobe, honoured only for the granted terminal
- op_code  in  2*NUM_TERM  per-terminal opcode, terminal i at [2i+1:2i]
- op_amount  in  AMT_W*NUM_TERM  per-terminal amount, terminal i at [AMT_W*i+AMT_W-1:AMT_W*i]
- grant  out  NUM_TERM  one-hot session owner, all-zero when idle
- resp_valid  out  1  one-cycle pulse, result of an operation or a timeout
- resp_status  out  2  00 OK, 01 insufficient funds, 10 overflow, 11 timeout
- balance  out  AMT_W  current ledger value, registered

## Operation
- States: IDLE, SESSION, EXEC.
- IDLE: if any req bit is high, select a winner round-robin starting at (last_owner+1) mod NUM_TERM, register grant, go to SESSION. After reset last_owner = NUM_TERM-1, so terminal 0 has first priority.
- SESSION: the owner's op_valid high accepts op_code/op_amount, clears the idle counter, and moves to EXEC. op_valid from non-owners is ignored with no response. The owner's req low (without op_valid) ends the session: grant goes to 0 and the FSM goes to IDLE with no response.
- Idle counter: counts SESSION cycles without an accepted op. On reaching TIMEOUT, it pulses resp_valid with status 11, clears grant, and goes to IDLE.
- EXEC (one cycle): applies the op, pulses resp_valid, then returns to SESSION if owner req is still high, else goes to IDLE with grant cleared.
- Opcodes: 00 query. 01 withdraw: if amount > balance, status 01, balance unchanged; else balance -= amount. 10 deposit: the sum is computed at AMT_W+1 bits; on carry, status 10, balance unchanged; else balance += amount. 11 is reserved and handled as query.
- A zero amount returns OK with no change. Response amounts are never truncated. The ledger saturates nowhere; it is only rejected.
- last_owner updates whenever a session ends (release or timeout).

## Timing
- Reset values: grant 0, resp_valid 0, resp_status 00, balance INIT_BALANCE, state IDLE, idle counter 0.
- req high in IDLE at edge N gives grant at N+1.
- op_valid accepted at edge M gives balance and resp_valid/resp_status valid after M+1, for exactly one cycle.
- The next op can be accepted at M+2; op_valid high during EXEC is ignored.
- Session end to next grant: at least one IDLE cycle. There are no back-to-back grants.
- Simultaneous op_valid and req drop in SESSION: the op executes, then the session ends after EXEC.
- Timeout and op_valid in the same cycle: the op wins and the counter clears.
- Reset asserted mid-session: grant drops asynchronously, any in-flight op is discarded, and the ledger returns to INIT_BALANCE.

## Structure
- Shared package atm_pkg: opcode constants (OP_QUERY, OP_WITHDRAW, OP_DEPOSIT), status constants (ST_OK, ST_NOFUNDS, ST_OVERFLOW, ST_TIMEOUT), state enum.
- Sub-module atm_rr_arbiter: combinational round-robin pick from req and last_owner, producing a one-hot winner and an any_req flag. The pointer register stays in the parent.

## Test plan
- Reset release, req=0001, op withdraw 28 -> grant=0001 one cycle later; resp OK, balance 100 two cycles after op_valid.
- Balance 100, withdraw 101 -> status 01, balance stays 100; deposit 200 (AMT_W=8) -> status 10, balance 100; deposit 155 -> OK, balance 255.
- req=1111 held, each owner drops req after one op -> grant sequence 0001, 0010, 0100, 1000, 0001, with one IDLE cycle between grants.
- Owner granted, no op_valid for 16 cycles -> resp_valid with status 11 on the timeout cycle; grant cleared; next requester granted.
- Non-owner op_valid during another's session -> no response, balance unchanged; reset low mid-EXEC -> grant 0, balance 128 immediately.

Source files
------------

// File: rtl/atm_pkg.sv
// atm_pkg
// Shared definitions for the ATM account arbiter:
//   - opcode encodings carried on each terminal's op_code lane
//   - response status encodings reported on resp_status
//   - session FSM state enum
package atm_pkg;

  // Opcodes
  localparam logic [1:0] OP_QUERY    = 2'b00;
  localparam logic [1:0] OP_WITHDRAW = 2'b01;
  localparam logic [1:0] OP_DEPOSIT  = 2'b10;
  // Reserved encoding, treated exactly like a query.
  localparam logic [1:0] OP_RESERVED = 2'b11;

  // Response status
  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_NOFUNDS  = 2'b01;
  localparam logic [1:0] ST_OVERFLOW = 2'b10;
  localparam logic [1:0] ST_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SESSION = 2'd1,
    S_EXEC    = 2'd2
  } state_t;

endpackage : atm_pkg

// File: rtl/atm_rr_arbiter.sv
// atm_rr_arbiter
// Combinational round-robin pick. The search starts at the terminal after
// last_owner and wraps, so the previous session owner has the lowest priority.
// The pointer register itself lives in the parent.
//
// Ports:
//   req        in   NUM_TERM  request vector
//   last_owner in   IDX_W     index of the previous session owner
//   winner     out  NUM_TERM  one-hot winner, zero when no request
//   winner_idx out  IDX_W     binary index of the winner
//   any_req    out  1         at least one request bit is set
module atm_rr_arbiter
  import atm_pkg::*;
#(
  parameter int NUM_TERM = 4,
  parameter int IDX_W    = $clog2(NUM_TERM)
) (
  input  logic [NUM_TERM-1:0] req,
  input  logic [IDX_W-1:0]    last_owner,
  output logic [NUM_TERM-1:0] winner,
  output logic [IDX_W-1:0]    winner_idx,
  output logic                any_req
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] sel;
    winner     = '0;
    winner_idx = '0;
    any_req    = |req;
    found      = 1'b0;
    sel        = '0;
    // Offsets 1..NUM_TERM from the pointer; offset NUM_TERM is the previous
    // owner itself, reached only when nobody else is requesting.
    for (int k = 1; k <= NUM_TERM; k++) begin
      sel = IDX_W'((int'(last_owner) + k) % NUM_TERM);
      if (!found && req[sel]) begin
        found       = 1'b1;
        winner[sel] = 1'b1;
        winner_idx  = sel;
      end
    end
  end

endmodule : atm_rr_arbiter

// File: rtl/atm_account_arbiter.sv
// atm_account_arbiter
// Shares one account ledger between NUM_TERM terminal front-ends. Sessions are
// granted round-robin, the owner's withdraw/deposit/query is applied to the
// ledger with underflow/overflow rejection, and idle sessions are revoked.
//
// Ports:
//   clk          in   1               system clock, rising edge
//   reset        in   1               asynchronous, active-low
//   req          in   NUM_TERM        per-terminal session request (level)
//   op_valid     in   NUM_TERM        per-terminal operation strobe
//   op_code      in   2*NUM_TERM      per-terminal opcode lanes
//   op_amount    in   AMT_W*NUM_TERM  per-terminal amount lanes
//   grant        out  NUM_TERM        one-hot session owner, zero when idle
//   resp_valid   out  1               one-cycle response pulse
//   resp_status  out  2               OK / no funds / overflow / timeout
//   balance      out  AMT_W           registered ledger value
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no owner; arbitrate on any req, grant registered next edge
// S_SESSION | owner holds the ledger; waits for op, release or timeout
// S_EXEC    | one cycle; latched op applied, response pulsed
module atm_account_arbiter
  import atm_pkg::*;
#(
  parameter int          NUM_TERM     = 4,
  parameter int          AMT_W        = 8,
  parameter int          TIMEOUT      = 16,
  parameter logic [AMT_W-1:0] INIT_BALANCE = AMT_W'(128)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_TERM-1:0]       req,
  input  logic [NUM_TERM-1:0]       op_valid,
  input  logic [2*NUM_TERM-1:0]     op_code,
  input  logic [AMT_W*NUM_TERM-1:0] op_amount,
  output logic [NUM_TERM-1:0]       grant,
  output logic                      resp_valid,
  output logic [1:0]                resp_status,
  output logic [AMT_W-1:0]          balance
);

  localparam int IDX_W = $clog2(NUM_TERM);
  localparam int CNT_W = $clog2(TIMEOUT);
  // Idle timer is a down-counter loaded at session (re)entry; reaching zero
  // with no op pending on the next SESSION cycle is the TIMEOUT-th idle cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [NUM_TERM-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      last_owner_q, last_owner_d;
  logic [CNT_W-1:0]      idle_cnt_q, idle_cnt_d;
  logic [1:0]            op_code_q, op_code_d;
  logic [AMT_W-1:0]      op_amount_q, op_amount_d;
  logic [AMT_W-1:0]      balance_q, balance_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [1:0]            resp_status_q, resp_status_d;

  logic [NUM_TERM-1:0]   arb_winner;
  logic [IDX_W-1:0]      arb_winner_idx;
  logic                  arb_any_req;

  logic                  owner_req;
  logic                  owner_op_valid;
  logic [1:0]            owner_code;
  logic [AMT_W-1:0]      owner_amount;

  logic [AMT_W:0]        dep_sum;
  logic [AMT_W-1:0]      exec_balance;
  logic [1:0]            exec_status;

  atm_rr_arbiter #(
    .NUM_TERM (NUM_TERM),
    .IDX_W    (IDX_W)
  ) u_rr_arbiter (
    .req        (req),
    .last_owner (last_owner_q),
    .winner     (arb_winner),
    .winner_idx (arb_winner_idx),
    .any_req    (arb_any_req)
  );

  // Select the current owner's request, strobe and operand lanes.
  always_comb begin
    owner_req      = 1'b0;
    owner_op_valid = 1'b0;
    owner_code     = OP_QUERY;
    owner_amount   = '0;
    for (int i = 0; i < NUM_TERM; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_req      = req[i];
        owner_op_valid = op_valid[i];
        owner_code     = op_code[2*i +: 2];
        owner_amount   = op_amount[AMT_W*i +: AMT_W];
      end
    end
  end

  // Ledger update for the latched op. Rejected ops leave the ledger untouched.
  assign dep_sum = {1'b0, balance_q} + {1'b0, op_amount_q};

  always_comb begin
    exec_balance = balance_q;
    exec_status  = ST_OK;
    case (op_code_q)
      OP_WITHDRAW: begin
        if (op_amount_q > balance_q) exec_status  = ST_NOFUNDS;
        else                         exec_balance = balance_q - op_amount_q;
      end
      OP_DEPOSIT: begin
        if (dep_sum[AMT_W]) exec_status  = ST_OVERFLOW;
        else                exec_balance = dep_sum[AMT_W-1:0];
      end
      OP_QUERY, OP_RESERVED: begin
        exec_balance = balance_q;
      end
      default: begin
        exec_balance = balance_q;
      end
    endcase
  end

  // State register (with the datapath registers it steers)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      last_owner_q  <= IDX_W'(NUM_TERM - 1);
      idle_cnt_q    <= '0;
      op_code_q     <= OP_QUERY;
      op_amount_q   <= '0;
      balance_q     <= INIT_BALANCE;
      resp_valid_q  <= 1'b0;
      resp_status_q <= ST_OK;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      idle_cnt_q    <= idle_cnt_d;
      op_code_q     <= op_code_d;
      op_amount_q   <= op_amount_d;
      balance_q     <= balance_d;
      resp_valid_q  <= resp_valid_d;
      resp_status_q <= resp_status_d;
    end
  end

  // Next-state logic. An accepted op takes precedence over release and
  // timeout; a release takes precedence over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (arb_any_req) state_d = S_SESSION;
      end
      S_SESSION: begin
        if (owner_op_valid)          state_d = S_EXEC;
        else if (!owner_req)         state_d = S_IDLE;
        else if (idle_cnt_q == '0)   state_d = S_IDLE;
      end
      S_EXEC: begin
        state_d = owner_req ? S_SESSION : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    grant_d       = grant_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    idle_cnt_d    = idle_cnt_q;
    op_code_d     = op_code_q;
    op_amount_d   = op_amount_q;
    balance_d     = balance_q;
    resp_valid_d  = 1'b0;
    resp_status_d = resp_status_q;
    case (state_q)
      S_IDLE: begin
        if (arb_any_req) begin
          grant_d    = arb_winner;
          owner_d    = arb_winner_idx;
          idle_cnt_d = CNT_LOAD;
        end
      end
      S_SESSION: begin
        if (owner_op_valid) begin
          op_code_d   = owner_code;
          op_amount_d = owner_amount;
          idle_cnt_d  = CNT_LOAD;
        end else if (!owner_req) begin
          grant_d      = '0;
          last_owner_d = owner_q;
          idle_cnt_d   = '0;
        end else if (idle_cnt_q == '0) begin
          resp_valid_d  = 1'b1;
          resp_status_d = ST_TIMEOUT;
          grant_d       = '0;
          last_owner_d  = owner_q;
        end else begin
          idle_cnt_d = idle_cnt_q - 1'b1;
        end
      end
      S_EXEC: begin
        balance_d     = exec_balance;
        resp_valid_d  = 1'b1;
        resp_status_d = exec_status;
        if (owner_req) begin
          idle_cnt_d = CNT_LOAD;
        end else begin
          grant_d      = '0;
          last_owner_d = owner_q;
          idle_cnt_d   = '0;
        end
      end
      default: begin
        grant_d = '0;
      end
    endcase
  end

  assign grant       = grant_q;
  assign resp_valid  = resp_valid_q;
  assign resp_status = resp_status_q;
  assign balance     = balance_q;

endmodule : atm_account_arbiter

// File: tb/tb_atm_account_arbiter.sv
// Bench for atm_account_arbiter: directed scenarios followed by randomized
// traffic, all checked against a transaction-level ledger/session model.
module tb_atm_account_arbiter;

  localparam int NT = 4;
  localparam int AW = 8;
  localparam int TO = 16;
  localparam int IB = 128;

  localparam logic [1:0] C_QUERY    = 2'b00;
  localparam logic [1:0] C_WITHDRAW = 2'b01;
  localparam logic [1:0] C_DEPOSIT  = 2'b10;

  logic              clk = 1'b0;
  logic              reset;
  logic [NT-1:0]     req;
  logic [NT-1:0]     op_valid;
  logic [2*NT-1:0]   op_code;
  logic [AW*NT-1:0]  op_amount;
  logic [NT-1:0]     grant;
  logic              resp_valid;
  logic [1:0]        resp_status;
  logic [AW-1:0]     balance;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_owner;   // -1 when no session
  int m_last;
  int m_bal;
  int m_idle;    // consecutive idle session cycles
  int m_status;
  bit m_rv;
  bit m_pend;    // accepted op awaiting execution
  int m_pcode;
  int m_pamt;

  atm_account_arbiter #(
    .NUM_TERM     (NT),
    .AMT_W        (AW),
    .TIMEOUT      (TO),
    .INIT_BALANCE (AW'(IB))
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .op_amount   (op_amount),
    .grant       (grant),
    .resp_valid  (resp_valid),
    .resp_status (resp_status),
    .balance     (balance)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner  = -1;
    m_last   = NT - 1;
    m_bal    = IB;
    m_idle   = 0;
    m_status = 0;
    m_rv     = 1'b0;
    m_pend   = 1'b0;
    m_pcode  = 0;
    m_pamt   = 0;
  endfunction

  function automatic void end_session();
    m_last  = m_owner;
    m_owner = -1;
    m_idle  = 0;
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  function automatic void model_edge();
    int max_bal;
    max_bal = (1 << AW) - 1;
    m_rv = 1'b0;
    if (m_pend) begin
      m_pend = 1'b0;
      m_rv   = 1'b1;
      m_status = 0;
      if (m_pcode == 1) begin
        if (m_pamt > m_bal) m_status = 1;
        else                m_bal = m_bal - m_pamt;
      end else if (m_pcode == 2) begin
        if (m_bal + m_pamt > max_bal) m_status = 2;
        else                          m_bal = m_bal + m_pamt;
      end
      if (!req[m_owner]) end_session();
      else               m_idle = 0;
    end else if (m_owner >= 0) begin
      if (op_valid[m_owner]) begin
        m_pend  = 1'b1;
        m_pcode = int'(op_code[2*m_owner +: 2]);
        m_pamt  = int'(op_amount[AW*m_owner +: AW]);
        m_idle  = 0;
      end else if (!req[m_owner]) begin
        end_session();
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_rv     = 1'b1;
          m_status = 3;
          end_session();
        end
      end
    end else begin
      for (int k = 1; k <= NT; k++) begin
        int cand;
        cand = (m_last + k) % NT;
        if (m_owner < 0 && req[cand]) m_owner = cand;
      end
      m_idle = 0;
    end
  endfunction

  task automatic step();
    logic [31:0] exp_grant;
    model_edge();
    @(posedge clk);
    #1;
    exp_grant = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
    check_eq("grant", {28'd0, grant}, exp_grant);
    check_eq("resp_valid", {31'd0, resp_valid}, {31'd0, m_rv});
    check_eq("balance", {24'd0, balance}, m_bal);
    if (m_rv) check_eq("resp_status", {30'd0, resp_status}, m_status);
  endtask

  task automatic do_op(input int t, input logic [1:0] code, input int amt);
    op_valid[t]          = 1'b1;
    op_code[2*t +: 2]    = code;
    op_amount[AW*t +: AW] = AW'(amt);
    step();
    op_valid[t] = 1'b0;
    step();
  endtask

  task automatic reset_cycle();
    req       = '0;
    op_valid  = '0;
    reset     = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    req       = '0;
    op_valid  = '0;
    op_code   = '0;
    op_amount = '0;
    model_reset();
    #12;
    check_eq("rst_grant", {28'd0, grant}, 0);
    check_eq("rst_resp_valid", {31'd0, resp_valid}, 0);
    check_eq("rst_resp_status", {30'd0, resp_status}, 0);
    check_eq("rst_balance", {24'd0, balance}, IB);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // First session: terminal 0, ledger arithmetic boundaries
    req = 4'b0001;
    step();
    check_eq("first_grant", {28'd0, grant}, 1);
    do_op(0, C_WITHDRAW, 28);
    check_eq("wd28_status", {30'd0, resp_status}, 0);
    check_eq("wd28_balance", {24'd0, balance}, 100);
    do_op(0, C_WITHDRAW, 101);
    check_eq("wd101_status", {30'd0, resp_status}, 1);
    check_eq("wd101_balance", {24'd0, balance}, 100);
    do_op(0, C_DEPOSIT, 200);
    check_eq("dep200_status", {30'd0, resp_status}, 2);
    check_eq("dep200_balance", {24'd0, balance}, 100);
    do_op(0, C_DEPOSIT, 155);
    check_eq("dep155_status", {30'd0, resp_status}, 0);
    check_eq("dep155_balance", {24'd0, balance}, 255);
    do_op(0, C_WITHDRAW, 0);
    check_eq("wd0_status", {30'd0, resp_status}, 0);
    check_eq("wd0_balance", {24'd0, balance}, 255);
    do_op(0, 2'b11, 7);
    check_eq("rsvd_status", {30'd0, resp_status}, 0);
    req = '0;
    step();
    check_eq("release_grant", {28'd0, grant}, 0);

    // Round robin: all request, each owner does one op and drops req with it
    reset_cycle();
    req = '1;
    step();
    for (int k = 0; k < 5; k++) begin
      int o;
      o = k % NT;
      check_eq("rr_grant", {28'd0, grant}, 32'd1 << o);
      op_valid[o]       = 1'b1;
      op_code[2*o +: 2] = C_QUERY;
      req[o]            = 1'b0;
      step();
      op_valid[o] = 1'b0;
      step();
      check_eq("rr_gap", {28'd0, grant}, 0);
      req[o] = 1'b1;
      step();
    end
    req = '0;
    step();
    step();

    // Timeout: last owner is terminal 1, so terminal 2 wins over terminal 0
    req = 4'b0101;
    step();
    check_eq("to_grant", {28'd0, grant}, 4);
    for (int i = 0; i < TO; i++) begin
      step();
      check_eq("to_rv", {31'd0, resp_valid}, (i == TO - 1) ? 1 : 0);
    end
    check_eq("to_status", {30'd0, resp_status}, 3);
    check_eq("to_cleared", {28'd0, grant}, 0);
    req[2] = 1'b0;
    step();
    check_eq("to_next", {28'd0, grant}, 1);

    // Non-owner strobes are ignored
    op_valid[1]          = 1'b1;
    op_code[3:2]         = C_WITHDRAW;
    op_amount[2*AW-1:AW] = AW'(50);
    repeat (3) step();
    op_valid[1] = 1'b0;
    check_eq("nonowner_balance", {24'd0, balance}, IB);

    // Reset in the middle of EXEC
    op_valid[0]     = 1'b1;
    op_code[1:0]    = C_DEPOSIT;
    op_amount[AW-1:0] = AW'(10);
    step();
    op_valid[0] = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_eq("midexec_grant", {28'd0, grant}, 0);
    check_eq("midexec_balance", {24'd0, balance}, IB);
    check_eq("midexec_rv", {31'd0, resp_valid}, 0);
    model_reset();
    req = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();

    // Randomized traffic
    begin
      bit lazy;
      lazy = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (cyc % 200 == 0) lazy = ($urandom_range(0, 3) == 0);
        for (int t = 0; t < NT; t++) begin
          if ($urandom_range(0, 15) == 0) req[t] = ~req[t];
          op_valid[t]       = lazy ? 1'b0 : ($urandom_range(0, 3) == 0);
          op_code[2*t +: 2] = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 3) == 0) op_amount[AW*t +: AW] = AW'($urandom_range(0, 255));
          else                           op_amount[AW*t +: AW] = AW'($urandom_range(0, 40));
        end
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_atm_account_arbiter
